// File: rtl/prefetch_queue_unit.sv
// Instruction prefetch queue: a three-state fetch FSM keeps at most one memory read in flight
// and pushes completed reads into a circular queue whose head feeds the decoder combinationally.
module prefetch_queue_unit #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_STEP = 2,
  parameter logic [INSTR_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               isFlush,
  input  logic               isAllStall,
  input  logic [INSTR_W-1:0] pcNext,
  output logic               memRd,
  output logic [INSTR_W-1:0] memAddr,
  input  logic [INSTR_W-1:0] memDataOut,
  input  logic               memDone,
  input  logic               memErr,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pcPlusTwo,
  output logic               instrValid,
  output logic               fetchMemErr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(DEPTH);
  localparam logic [INSTR_W-1:0] Step = INSTR_W'(PC_STEP);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e             stateQ;
  logic [INSTR_W-1:0] fetchPcQ;
  logic [PtrW:0]      countQ;
  logic [PtrW:0]      countNext;
  logic [PtrW-1:0]    wrPtrQ;
  logic [PtrW-1:0]    rdPtrQ;
  logic               errQ;
  logic               push;
  logic               pop;

  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [INSTR_W-1:0] pcMem [DEPTH];

  always_comb begin
    push      = !isFlush && (stateQ == StBusy) && memDone && (countQ != Full);
    pop       = !isFlush && (countQ != '0) && !isAllStall;
    countNext = countQ + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= StIdle;
      fetchPcQ <= RESET_PC;
      countQ   <= '0;
      wrPtrQ   <= '0;
      rdPtrQ   <= '0;
      errQ     <= 1'b0;
    end else begin
      if (memDone && memErr && (stateQ != StIdle)) begin
        errQ <= 1'b1;
      end
      if (isFlush) begin
        fetchPcQ <= pcNext;
        countQ   <= '0;
        wrPtrQ   <= '0;
        rdPtrQ   <= '0;
        // A read completing alongside the flush is retired here, so no drain is needed.
        if (stateQ == StBusy && !memDone) begin
          stateQ <= StDrain;
        end else if (stateQ == StDrain && memDone) begin
          stateQ <= StBusy;
        end
      end else begin
        countQ <= countNext;
        if (push) begin
          wrPtrQ   <= wrPtrQ + PtrW'(1);
          fetchPcQ <= fetchPcQ + Step;
        end
        if (pop) begin
          rdPtrQ <= rdPtrQ + PtrW'(1);
        end
        case (stateQ)
          StIdle:  if (countQ != Full) stateQ <= StBusy;
          StBusy:  if (push && countNext == Full) stateQ <= StIdle;
          StDrain: if (memDone) stateQ <= StBusy;
          default: stateQ <= StIdle;
        endcase
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instrMem[wrPtrQ] <= memDataOut;
      pcMem[wrPtrQ]    <= fetchPcQ + Step;
    end
  end

  always_comb begin
    memRd       = !rst && (stateQ == StBusy);
    memAddr     = fetchPcQ;
    instrValid  = !rst && (countQ != '0);
    instr       = instrValid ? instrMem[rdPtrQ] : NOP_INSTR;
    pcPlusTwo   = instrValid ? pcMem[rdPtrQ] : '0;
    fetchMemErr = errQ;
  end

endmodule

// File: tb/tb_prefetch_queue_unit.sv
// Directed bench for prefetch_queue_unit; memory returns address + 16'h1000 as its data word.
module tb_prefetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        isFlush;
  logic        isAllStall;
  logic [15:0] pcNext;
  logic        memRd;
  logic [15:0] memAddr;
  logic [15:0] memDataOut;
  logic        memDone;
  logic        memErr;
  logic [15:0] instr;
  logic [15:0] pcPlusTwo;
  logic        instrValid;
  logic        fetchMemErr;

  logic        autoMem;
  logic        manDone;
  int          checks = 0;
  int          errors = 0;

  assign memDataOut = memAddr + 16'h1000;
  assign memDone    = autoMem ? memRd : manDone;

  prefetch_queue_unit dut (
    .clk        (clk),
    .rst        (rst),
    .isFlush    (isFlush),
    .isAllStall (isAllStall),
    .pcNext     (pcNext),
    .memRd      (memRd),
    .memAddr    (memAddr),
    .memDataOut (memDataOut),
    .memDone    (memDone),
    .memErr     (memErr),
    .instr      (instr),
    .pcPlusTwo  (pcPlusTwo),
    .instrValid (instrValid),
    .fetchMemErr(fetchMemErr)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; isFlush = 1'b0; isAllStall = 1'b0; pcNext = '0;
    memErr = 1'b0; autoMem = 1'b0; manDone = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_memRd", {15'd0, memRd}, 16'd0);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_valid", {15'd0, instrValid}, 16'd0);
    rst = 1'b0;
    #1;
    chk("idle_memRd", {15'd0, memRd}, 16'd0);
    chk("idle_addr", memAddr, 16'h0000);

    // Zero-wait streaming
    autoMem = 1'b1;
    tick();
    chk("s1_memRd", {15'd0, memRd}, 16'd1);
    chk("s1_addr", memAddr, 16'h0000);
    chk("s1_valid", {15'd0, instrValid}, 16'd0);
    tick();
    chk("s2_addr", memAddr, 16'h0002);
    chk("s2_valid", {15'd0, instrValid}, 16'd1);
    chk("s2_instr", instr, 16'h1000);
    chk("s2_pc2", pcPlusTwo, 16'h0002);
    tick();
    chk("s3_addr", memAddr, 16'h0004);
    chk("s3_instr", instr, 16'h1002);
    chk("s3_pc2", pcPlusTwo, 16'h0004);

    // Stall held: queue fills with exactly four entries
    doReset();
    isAllStall = 1'b1;
    tick();
    tick();
    chk("st_busy_memRd", {15'd0, memRd}, 16'd1);
    tick();
    tick();
    tick();
    chk("st_full_memRd", {15'd0, memRd}, 16'd0);
    chk("st_full_addr", memAddr, 16'h0008);
    chk("st_full_instr", instr, 16'h1000);
    chk("st_full_pc2", pcPlusTwo, 16'h0002);
    tick();
    tick();
    chk("st_hold_memRd", {15'd0, memRd}, 16'd0);
    chk("st_hold_instr", instr, 16'h1000);
    isAllStall = 1'b0;
    tick();
    chk("st_pop1_instr", instr, 16'h1002);
    chk("st_pop1_memRd", {15'd0, memRd}, 16'd0);
    tick();
    chk("st_pop2_instr", instr, 16'h1004);
    chk("st_pop2_memRd", {15'd0, memRd}, 16'd1);
    chk("st_pop2_addr", memAddr, 16'h0008);

    // Flush during an outstanding 3-cycle read
    autoMem = 1'b0;
    doReset();
    isAllStall = 1'b1;
    tick();
    chk("fl_busy_addr", memAddr, 16'h0000);
    tick();
    isFlush = 1'b1; pcNext = 16'h0040;
    tick();
    isFlush = 1'b0;
    chk("fl_drain_memRd", {15'd0, memRd}, 16'd0);
    chk("fl_drain_addr", memAddr, 16'h0040);
    chk("fl_drain_valid", {15'd0, instrValid}, 16'd0);
    manDone = 1'b1;
    tick();
    manDone = 1'b0;
    chk("fl_rebusy_memRd", {15'd0, memRd}, 16'd1);
    chk("fl_rebusy_addr", memAddr, 16'h0040);
    chk("fl_dropped_valid", {15'd0, instrValid}, 16'd0);
    manDone = 1'b1;
    tick();
    manDone = 1'b0;
    chk("fl_new_valid", {15'd0, instrValid}, 16'd1);
    chk("fl_new_instr", instr, 16'h1040);
    chk("fl_new_pc2", pcPlusTwo, 16'h0042);

    // Flush coincident with memDone
    manDone = 1'b1; isFlush = 1'b1; pcNext = 16'h0100;
    tick();
    manDone = 1'b0; isFlush = 1'b0;
    chk("fd_memRd", {15'd0, memRd}, 16'd1);
    chk("fd_addr", memAddr, 16'h0100);
    chk("fd_valid", {15'd0, instrValid}, 16'd0);

    // Sticky memory error on the second read
    doReset();
    isAllStall = 1'b0;
    tick();
    manDone = 1'b1;
    tick();
    chk("er_first", {15'd0, fetchMemErr}, 16'd0);
    memErr = 1'b1;
    tick();
    memErr = 1'b0; manDone = 1'b0;
    chk("er_set", {15'd0, fetchMemErr}, 16'd1);
    chk("er_data_kept", instr, 16'h1002);
    tick();
    tick();
    chk("er_hold", {15'd0, fetchMemErr}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("er_clear", {15'd0, fetchMemErr}, 16'd0);

    // PC wrap with a push and pop in the same cycle
    doReset();
    isAllStall = 1'b1; isFlush = 1'b1; pcNext = 16'hFFF8;
    tick();
    isFlush = 1'b0;
    chk("wr_idle_memRd", {15'd0, memRd}, 16'd0);
    chk("wr_idle_addr", memAddr, 16'hFFF8);
    tick();
    manDone = 1'b1;
    tick();
    tick();
    tick();
    chk("wr_pre_addr", memAddr, 16'hFFFE);
    isAllStall = 1'b0;
    tick();
    chk("wr_wrap_addr", memAddr, 16'h0000);
    chk("wr_wrap_memRd", {15'd0, memRd}, 16'd1);
    chk("wr_wrap_instr", instr, 16'h0FFA);
    isAllStall = 1'b1;
    tick();
    manDone = 1'b0;
    chk("wr_full_memRd", {15'd0, memRd}, 16'd0);
    chk("wr_full_instr", instr, 16'h0FFA);
    chk("wr_full_addr", memAddr, 16'h0002);
    isAllStall = 1'b0;
    tick();
    chk("wr_pop1_instr", instr, 16'h0FFC);
    chk("wr_pop1_pc2", pcPlusTwo, 16'hFFFE);
    tick();
    chk("wr_pop2_instr", instr, 16'h0FFE);
    chk("wr_pop2_pc2", pcPlusTwo, 16'h0000);
    chk("wr_pop2_memRd", {15'd0, memRd}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
